// File: rtl/iddmm_sched_pkg.sv
// Shared types and the round-robin pick function for the Montgomery core scheduler.
package iddmm_sched_pkg;

    localparam int unsigned MAX_R    = 8;
    localparam int unsigned MAX_ID_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAUNCH,
        WAIT,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] id;
    } rr_pick_t;

    // First set request at or above ptr, wrapping at r requesters.
    function automatic rr_pick_t rr_pick(input logic [MAX_R-1:0]    req,
                                         input logic [MAX_ID_W-1:0] ptr,
                                         input int unsigned         r);
        rr_pick_t          res;
        logic [MAX_ID_W:0] idx;
        res = '0;
        for (int unsigned i = 0; i < MAX_R; i++) begin
            idx = {1'b0, ptr} + (MAX_ID_W+1)'(i);
            if (32'(idx) >= r) begin
                idx = idx - (MAX_ID_W+1)'(r);
            end
            if (i < r && !res.found && req[idx[MAX_ID_W-1:0]]) begin
                res.found = 1'b1;
                res.id    = idx[MAX_ID_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/iddmm_sched_rr_arbiter.sv
// Round-robin requester selection; the pointer moves past the owner when a job completes.
module rr_arbiter
    import iddmm_sched_pkg::*;
#(
    parameter int unsigned R    = 4,
    parameter int unsigned ID_W = $clog2(R)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [R-1:0]    req,
    input  logic            advance,
    input  logic [ID_W-1:0] last_id,
    output logic            found_c,
    output logic [ID_W-1:0] id_c
);

    logic [ID_W-1:0] ptr_q;
    rr_pick_t        pick;

    always_comb begin
        pick    = rr_pick(MAX_R'(req), MAX_ID_W'(ptr_q), R);
        found_c = pick.found;
        id_c    = ID_W'(pick.id);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (32'(last_id) == R - 1) ? '0 : ID_W'(32'(last_id) + 1);
        end
    end

endmodule

// File: rtl/iddmm_sched.sv
// Shares one Montgomery multiplier core between R requesters: load operands,
// launch the task and route the result words back to the owner.
module iddmm_sched
    import iddmm_sched_pkg::*;
#(
    parameter int unsigned K      = 128,
    parameter int unsigned N      = 32,
    parameter int unsigned R      = 4,
    parameter int unsigned ADDR_W = $clog2(N),
    parameter int unsigned ID_W   = $clog2(R)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [R-1:0]      req,
    input  logic [R*K-1:0]    req_m1,
    output logic [ADDR_W-1:0] op_rd_addr,
    output logic [R-1:0]      op_rd_en,
    input  logic [R*K-1:0]    op_x,
    input  logic [R*K-1:0]    op_y,
    input  logic [R*K-1:0]    op_m,
    output logic [R-1:0]      grant,
    output logic [R-1:0]      res_vld,
    output logic [K-1:0]      res_data,
    output logic              res_last,
    output logic [R-1:0]      done,
    output logic              busy,
    output logic [2:0]        mm_wr_ena,
    output logic [ADDR_W-1:0] mm_wr_addr,
    output logic [K-1:0]      mm_wr_x,
    output logic [K-1:0]      mm_wr_y,
    output logic [K-1:0]      mm_wr_m,
    output logic [K-1:0]      mm_wr_m1,
    output logic              mm_task_req,
    input  logic              mm_task_grant,
    input  logic              mm_task_end,
    input  logic [K-1:0]      mm_task_res
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [R-1:0]    grant_q, grant_d;
    logic [K-1:0]    m1_q, m1_d;
    logic            arb_found_c;
    logic [ID_W-1:0] arb_id_c;
    logic            last_word_c;

    rr_arbiter #(
        .R    (R),
        .ID_W (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (state_q == DONE),
        .last_id (id_q),
        .found_c (arb_found_c),
        .id_c    (arb_id_c)
    );

    assign last_word_c = (cnt_q == CNT_W'(N - 1));
    assign grant       = grant_q;
    assign mm_wr_m1    = m1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            grant_q <= '0;
            m1_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            grant_q <= grant_d;
            m1_q    <= m1_d;
        end
    end

    // Next state; the word counter serves both the load and the drain phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        grant_d = grant_q;
        m1_d    = m1_q;
        unique case (state_q)
            IDLE: begin
                if (arb_found_c) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    id_d    = arb_id_c;
                    grant_d = R'(1) << arb_id_c;
                    m1_d    = req_m1[32'(arb_id_c)*K +: K];
                end
            end
            LOAD: begin
                if (cnt_q == CNT_W'(N)) begin
                    state_d = LAUNCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LAUNCH: begin
                if (mm_task_grant) begin
                    state_d = WAIT;
                end
            end
            WAIT, DRAIN: begin
                if (mm_task_end) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = last_word_c ? DONE : DRAIN;
                end
            end
            DONE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Writes trail reads by one cycle because the requester read port is synchronous.
    always_comb begin
        op_rd_en    = '0;
        op_rd_addr  = '0;
        mm_wr_ena   = '0;
        mm_wr_addr  = '0;
        mm_wr_x     = '0;
        mm_wr_y     = '0;
        mm_wr_m     = '0;
        mm_task_req = 1'b0;
        res_vld     = '0;
        res_data    = '0;
        res_last    = 1'b0;
        done        = '0;
        busy        = (state_q != IDLE);
        case (state_q)
            LOAD: begin
                if (cnt_q < CNT_W'(N)) begin
                    op_rd_en   = grant_q;
                    op_rd_addr = cnt_q[ADDR_W-1:0];
                end
                if (cnt_q != '0) begin
                    mm_wr_ena  = 3'b111;
                    mm_wr_addr = ADDR_W'(cnt_q - CNT_W'(1));
                    mm_wr_x    = op_x[32'(id_q)*K +: K];
                    mm_wr_y    = op_y[32'(id_q)*K +: K];
                    mm_wr_m    = op_m[32'(id_q)*K +: K];
                end
            end
            LAUNCH: mm_task_req = 1'b1;
            WAIT, DRAIN: begin
                if (mm_task_end) begin
                    res_vld  = grant_q;
                    res_data = mm_task_res;
                    res_last = last_word_c;
                end
            end
            DONE: done = grant_q;
            default: ;
        endcase
    end

endmodule

// File: doc/iddmm_sched.md
Name: iddmm_sched

Overview:
- Round-robin scheduler that shares one Montgomery multiplier core (iddmm_top interface) between R requesters.
- For each granted job it:
  - reads the requester's operand words (x, y, m) through a synchronous read port;
  - loads them into the core's operand RAMs;
  - launches the task;
  - routes the N result words back to the owning requester.
- Sits between the Paillier exponentiation engines and the single shared multiplier instance.

Parameters:
- K, 128, bits per word (must match the core)
- N, 32, words per operand (must match the core)
- R, 4, number of requesters (2..8)
- ADDR_W, $clog2(N), word address width
- ID_W, $clog2(R), requester index width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- req  in  R  per-requester job request, level, held until its done pulse
- req_m1  in  R*K  per-requester Montgomery constant -m^-1 mod 2^K; requester r at [r*K +: K]
- op_rd_addr  out  ADDR_W  word address presented to all requesters
- op_rd_en  out  R  one-hot read strobe to granted requester
- op_x  in  R*K  requester x word, valid 1 cycle after op_rd_en
- op_y  in  R*K  requester y word, same timing
- op_m  in  R*K  requester m word, same timing
- grant  out  R  one-hot owner of the core, held for whole job
- res_vld  out  R  one-hot, result word valid to owner
- res_data  out  K  result word, LSW first
- res_last  out  1  with final result word
- done  out  R  one-hot 1-cycle pulse, cycle after res_last
- busy  out  1  high whenever state != IDLE
- mm_wr_ena  out  3  to core wr_ena (bit0 x, bit1 y, bit2 m)
- mm_wr_addr  out  ADDR_W  to core wr_addr
- mm_wr_x  out  K  to core wr_x
- mm_wr_y  out  K  to core wr_y
- mm_wr_m  out  K  to core wr_m
- mm_wr_m1  out  K  to core wr_m1, req_m1 of owner, stable for whole job
- mm_task_req  out  1  to core task_req
- mm_task_grant  in  1  core accepted task (1-cycle pulse)
- mm_task_end  in  1  core result word valid; high N consecutive cycles
- mm_task_res  in  K  core result word

Behaviour:
- Reset (rst_n low at posedge): state IDLE.
  - All outputs 0 (grant, op_rd_en, res_vld, done, mm_wr_ena, mm_task_req, busy, addresses, data).
  - Round-robin pointer resets to 0.
  - Reset mid-job aborts the job; no done is issued.
- States: IDLE, LOAD, LAUNCH, WAIT, DRAIN, DONE.
- IDLE:
  - If any req is high, select the first set bit searching from ptr upward (wrapping).
  - Next cycle: grant = onehot(id), state LOAD, word counter = 0.
- LOAD:
  - Cycle c (0..N-1): op_rd_en = grant, op_rd_addr = c.
  - Cycle c+1: mm_wr_ena = 3'b111, mm_wr_addr = c, mm_wr_x/y/m = owner's op words.
  - Writes are pipelined one cycle behind reads, so LOAD lasts N+1 cycles, then LAUNCH.
- LAUNCH:
  - mm_task_req = 1 held until the cycle mm_task_grant = 1 is sampled.
  - Then deassert and go to WAIT.
  - A grant pulse arriving in the first LAUNCH cycle is accepted.
- WAIT: on the first mm_task_end = 1, go to DRAIN; that same word is forwarded.
- DRAIN (forwarding):
  - Each cycle mm_task_end = 1: res_vld = grant, res_data = mm_task_res; same-cycle combinational pass-through, 0 latency.
  - Result word counter increments; res_last is asserted on word N-1; then DONE.
  - mm_task_end low inside the drain window is a protocol error. The counter holds, res_vld = 0, and the state is unchanged.
- DONE:
  - One cycle: done = grant.
  - ptr = id+1 mod R.
  - grant cleared, state IDLE.
- req dropped mid-job is ignored; the job completes and done still pulses.
- A new job is selected at the earliest in the IDLE cycle after DONE, so there is a minimum of one idle cycle between jobs.
- Simultaneous requests: strict round-robin from ptr. No requester waits more than R-1 jobs.
- mm_task_end while in IDLE, LOAD or LAUNCH is ignored.
- Counter widths:
  - Word counter is ADDR_W+1 bits, so N equal to a power of 2 needs no wrap.
  - id wraps at R.
- Total job latency, grant to done: (N+1) + launch wait + core latency + N + 1 cycles.

Decomposition:
- Package iddmm_sched_pkg holds:
  - state enum typedef (IDLE..DONE);
  - function rr_pick(req, ptr) returning the id plus a found flag.
- Sub-module rr_arbiter holds the round-robin selection and pointer register. Everything else stays in iddmm_sched.

Test Plan (bench uses a behavioural core model: grant 2 cycles after task_req, then N end cycles of x*y*R^-1 mod m; K=16, N=4, R=3):
1. Single request:
   - Stimulus: req=3'b001; x=0x0003_0000_0000_0001, y=2, m=0x8000_0000_0000_0001 word-wise.
   - Response: 4 mm_wr_ena=7 cycles at addr 0..3; one task_req; res_vld=001 for 4 words; res_last on word 3; done=001 the next cycle.
2. Round robin:
   - Stimulus: req=3'b111 held continuously.
   - Response: grant sequence 001,010,100,001; done pulses in that order; one IDLE cycle between jobs.
3. Pointer fairness:
   - Stimulus: requester 2 finishes, then req=3'b101.
   - Response: next grant=001, not 100.
4. Drop request mid-job:
   - Stimulus: req[1] deasserted during WAIT.
   - Response: job finishes, 4 res words routed to requester 1, done=010.
5. Stalled core:
   - Stimulus: model delays mm_task_grant by 20 cycles, then inserts a 3-cycle mm_task_end gap after word 1.
   - Response: task_req held 20 cycles; res_vld low during the gap; still exactly 4 words and res_last on the 4th.
6. Reset mid-DRAIN:
   - Stimulus: rst_n=0 for 1 cycle after word 2.
   - Response: all outputs 0 next cycle, no done; after rst_n=1 with req=3'b010, grant=010 (ptr=0 search).
